// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pulls words from an async FIFO into a
// 2-entry skid buffer and presents them as a valid/ready stream.
module fifo_rd_stream #(
  parameter int DATAWIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 empty,
  input  logic [DATAWIDTH-1:0] Rdata,
  output logic                 rd,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_infl;
  logic                 r_head;
  logic [DATAWIDTH-1:0] r_buf0;
  logic [DATAWIDTH-1:0] r_buf1;
  logic [CNT_WIDTH-1:0] r_beat;

  logic       w_pop;
  logic       w_cap;
  logic       w_tail;
  logic [1:0] w_occ;
  logic [2:0] w_level;

  assign w_occ   = r_state;
  assign m_valid = (r_state != S_EMPTY);
  assign w_pop   = m_valid && m_ready && !flush;
  assign w_cap   = r_infl && !flush;

  // Room check includes the word already in flight and this cycle's pop.
  assign w_level = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};
  assign rd      = en && !empty && !flush && !rrst && (w_level < 3'd2);

  assign w_tail  = r_head ^ (r_state == S_ONE);
  assign m_data  = r_head ? r_buf1 : r_buf0;
  assign beat_cnt = r_beat;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_cap) w_state_nxt = S_ONE;
        end
        S_ONE: begin
          if (w_cap && !w_pop)      w_state_nxt = S_TWO;
          else if (w_pop && !w_cap) w_state_nxt = S_EMPTY;
          else                      w_state_nxt = S_ONE;
        end
        S_TWO: begin
          if (w_pop) w_state_nxt = S_ONE;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_state <= S_EMPTY;
      r_infl  <= 1'b0;
      r_head  <= 1'b0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_infl  <= rd;
      if (w_pop) begin
        r_head <= ~r_head;
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else if (w_cap) begin
      if (w_tail) r_buf1 <= Rdata;
      else        r_buf0 <= Rdata;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural FIFO
// that returns Rdata one cycle after each rd.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          en = 1'b1;
  logic          flush = 1'b0;
  logic          empty;
  logic [DW-1:0] Rdata = '0;
  logic          rd;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] beat_cnt;

  logic          force_empty = 1'b0;
  int            fq_n = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            rd_cnt = 0;
  int            rd_base;

  assign empty = (fq_n == 0) || force_empty;

  fifo_rd_stream #(.DATAWIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rclk(rclk), .rrst(rrst), .en(en), .flush(flush),
    .empty(empty), .Rdata(Rdata), .rd(rd),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .beat_cnt(beat_cnt)
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (rd && fq.size() > 0) Rdata <= fq.pop_front();
    fq_n <= fq.size();
  end

  always @(negedge rclk) begin
    logic [DW-1:0] e;
    if (rd) rd_cnt++;
    if (empty && !rrst) begin
      n_vec++;
      if (rd) begin
        n_err++;
        $display("FAIL rd_while_empty: rd=%0b required 0", rd);
      end
    end
    if (m_valid && m_ready && !flush && !rrst) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got %02h, none required", m_data);
      end else begin
        e = sb.pop_front();
        if (m_data !== e) begin
          n_err++;
          $display("FAIL stream_data: got %02h required %02h", m_data, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, a, e);
    end
  endtask

  task automatic put(input logic [DW-1:0] d, input bit exp);
    fq.push_back(d);
    if (exp) sb.push_back(d);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || m_valid) && t < 300) begin
      step(1);
      t++;
    end
    chk("drain_timeout", t < 300, 1);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    fq.delete();
    sb.delete();
    step(2);
    rrst = 1'b0;
  endtask

  initial begin
    // 1. reset with data presented
    put(8'hAA, 0);
    step(2);
    @(negedge rclk);
    chk("rst_empty_low", empty, 0);
    chk("rst_rd", rd, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_data", m_data, 0);
    do_reset();

    // 2. full-rate stream
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) put(DW'(i), 1);
    step(1);
    @(negedge rclk);
    chk("lat_rd_n", rd, 1);
    chk("lat_valid_n", m_valid, 0);
    step(1);
    @(negedge rclk);
    chk("lat_valid_n1", m_valid, 0);
    step(1);
    @(negedge rclk);
    chk("lat_valid_n2", m_valid, 1);
    chk("lat_data_n2", m_data, 8'h01);
    for (int i = 0; i < 7; i++) begin
      step(1);
      @(negedge rclk);
      chk("stream_gapless", m_valid, 1);
    end
    drain();
    chk("stream_beats", beat_cnt, 8);

    // 3. backpressure
    m_ready = 1'b0;
    rd_base = rd_cnt;
    put(8'h01, 1);
    put(8'h02, 1);
    put(8'h03, 1);
    step(6);
    chk("bp_rd_pulses", rd_cnt - rd_base, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_hold_data", m_data, 8'h01);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      chk("bp_release_gapless", m_valid, 1);
      step(1);
    end
    drain();
    chk("bp_beats", beat_cnt, 11);

    // 4. bursty empty, random ready
    for (int i = 0; i < 12; i++) put(8'h10 + DW'(i), 1);
    for (int i = 0; i < 60; i++) begin
      force_empty = ~force_empty;
      m_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    force_empty = 1'b0;
    m_ready = 1'b1;
    drain();
    chk("burst_beats", beat_cnt, 7);

    // 5. flush with one stored and one in flight
    m_ready = 1'b0;
    put(8'h21, 0);
    put(8'h22, 0);
    put(8'h23, 1);
    put(8'h24, 1);
    step(3);
    flush = 1'b1;
    @(negedge rclk);
    chk("flush_pre_valid", m_valid, 1);
    chk("flush_rd", rd, 0);
    step(1);
    flush = 1'b0;
    @(negedge rclk);
    chk("flush_valid", m_valid, 0);
    m_ready = 1'b1;
    drain();
    chk("flush_beats", beat_cnt, 9);

    // 6. counter wrap and mid-stream reset
    do_reset();
    chk("wrap_start", beat_cnt, 0);
    for (int i = 0; i < 17; i++) put(8'h40 + DW'(i), 1);
    drain();
    chk("wrap_beats", beat_cnt, 1);
    for (int i = 0; i < 8; i++) put(8'h60 + DW'(i), 1);
    step(4);
    chk("mid_valid", m_valid, 1);
    rrst = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_beat", beat_cnt, 0);
    chk("mid_rst_rd", rd, 0);
    fq.delete();
    sb.delete();
    step(2);
    rrst = 1'b0;
    put(8'h70, 1);
    drain();
    chk("post_rst_beats", beat_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
